// File: rtl/regfile_mp_pkg.sv
// Shared constants for the multi-port integer register file: XLEN, load funct3
// encodings and the address-width helper.
package regfile_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] LB_F3  = 3'b000;
    localparam logic [2:0] LH_F3  = 3'b001;
    localparam logic [2:0] LW_F3  = 3'b010;
    localparam logic [2:0] LBU_F3 = 3'b100;
    localparam logic [2:0] LHU_F3 = 3'b101;

    function automatic int addr_w(input int num_regs);
        return (num_regs <= 2) ? 1 : $clog2(num_regs);
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Bus between the ID/WB stages (master) and the register file (slave):
// read ports, write ports with load info, and scoreboard set.
interface regfile_mp_if #(
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int ADDR_W   = regfile_pkg::addr_w(NUM_REGS)
) ();

    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*32-1:0]     rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic [NUM_WR-1:0]        wr_en;
    logic [NUM_WR*ADDR_W-1:0] wr_addr;
    logic [NUM_WR*32-1:0]     wr_data;
    logic [NUM_WR-1:0]        wr_is_load;
    logic [NUM_WR*3-1:0]      wr_funct3;
    logic [NUM_WR*2-1:0]      wr_byte_off;
    logic [NUM_WR-1:0]        wr_clr_busy;
    logic                     sb_set_en;
    logic [ADDR_W-1:0]        sb_set_addr;
    logic                     any_busy;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, wr_is_load, wr_funct3,
               wr_byte_off, wr_clr_busy, sb_set_en, sb_set_addr,
        input  rd_data, rd_busy, any_busy
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, wr_is_load, wr_funct3,
               wr_byte_off, wr_clr_busy, sb_set_en, sb_set_addr,
        output rd_data, rd_busy, any_busy
    );

endinterface

// File: rtl/regfile_mp_load_ext_unit.sv
// Combinational load aligner/extender: picks the addressed byte/halfword of the
// raw memory word and sign- or zero-extends it; non-loads pass through.
module load_ext_unit
    import regfile_pkg::*;
(
    input  logic [XLEN-1:0] data_i,
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      byte_off_i,
    input  logic            is_load_i,
    output logic [XLEN-1:0] value_o
);

    function automatic logic [XLEN-1:0] sext8(input logic signed [7:0] b);
        return XLEN'(b);
    endfunction

    function automatic logic [XLEN-1:0] sext16(input logic signed [15:0] h);
        return XLEN'(h);
    endfunction

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Halfword offset bit 0 is ignored; misaligned halfwords trap upstream.
    always_comb begin
        byte_sel = data_i[8*byte_off_i +: 8];
        half_sel = byte_off_i[1] ? data_i[31:16] : data_i[15:0];
        value_o  = data_i;
        if (is_load_i) begin
            case (funct3_i)
                LB_F3:   value_o = sext8(byte_sel);
                LH_F3:   value_o = sext16(half_sel);
                LW_F3:   value_o = data_i;
                LBU_F3:  value_o = {24'h0, byte_sel};
                LHU_F3:  value_o = {16'h0, half_sel};
                default: value_o = data_i;
            endcase
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port RV32 integer register file with load extension and busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to the read ports.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1
) (
    input  logic         clk,
    input  logic         rst,
    regfile_mp_if.slave  bus
);

    localparam int ADDR_W = addr_w(NUM_REGS);

    logic [XLEN-1:0]   regs_q [NUM_REGS];
    logic [XLEN-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    logic [XLEN-1:0]   wval [NUM_WR];
    logic [ADDR_W-1:0] wa   [NUM_WR];
    logic [ADDR_W-1:0] ra   [NUM_RD];

    for (genvar w = 0; w < NUM_WR; w++) begin : g_wr
        assign wa[w] = bus.wr_addr[w*ADDR_W +: ADDR_W];

        load_ext_unit u_ext (
            .data_i     (bus.wr_data[w*XLEN +: XLEN]),
            .funct3_i   (bus.wr_funct3[w*3 +: 3]),
            .byte_off_i (bus.wr_byte_off[w*2 +: 2]),
            .is_load_i  (bus.wr_is_load[w]),
            .value_o    (wval[w])
        );
    end

    // Ports are applied in ascending order so the highest index wins both the
    // data and the busy-clear decision; the ID set is applied last (newer producer).
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int w = 0; w < NUM_WR; w++) begin
            if (bus.wr_en[w] && (wa[w] != '0)) begin
                regs_d[wa[w]] = wval[w];
                busy_d[wa[w]] = bus.wr_clr_busy[w] ? 1'b0 : busy_q[wa[w]];
            end
        end
        if (bus.sb_set_en && (bus.sb_set_addr != '0)) begin
            busy_d[bus.sb_set_addr] = 1'b1;
        end
        regs_d[0] = '0;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q <= '{default: '0};
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [XLEN-1:0] data;
        logic            busy;

        assign ra[p] = bus.rd_addr[p*ADDR_W +: ADDR_W];

        always_comb begin
            data = regs_q[ra[p]];
            busy = busy_q[ra[p]];
`ifdef REGFILE_BYPASS_EN
            for (int w = 0; w < NUM_WR; w++) begin
                if (bus.wr_en[w] && (wa[w] == ra[p]) && (ra[p] != '0)) begin
                    data = wval[w];
                    busy = (bus.wr_clr_busy[w] &&
                            !(bus.sb_set_en && (bus.sb_set_addr == ra[p])))
                           ? 1'b0 : busy_q[ra[p]];
                end
            end
`endif
        end

        assign bus.rd_data[p*XLEN +: XLEN] = data;
        assign bus.rd_busy[p]              = busy;
    end

    assign bus.any_busy = |busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (16 regs, 4 read, 2 write ports) against a
// behavioural array model; honours REGFILE_BYPASS_EN.
module tb_regfile_mp;

    localparam int NR  = 16;
    localparam int NRD = 4;
    localparam int NWR = 2;
    localparam int AW  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] m_reg  [NR];
    bit          m_busy [NR];

    regfile_mp_if #(.NUM_REGS(NR), .NUM_RD(NRD), .NUM_WR(NWR)) bus ();

    regfile_mp #(.NUM_REGS(NR), .NUM_RD(NRD), .NUM_WR(NWR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [31:0] m_ext(input logic [31:0] d, input logic [2:0] f3,
                                          input logic [1:0] off, input logic ld);
        int unsigned b, h;
        if (!ld) return d;
        b = (d >> (8 * off)) & 32'hFF;
        h = (d >> (off[1] ? 16 : 0)) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return d;
        endcase
    endfunction

    function automatic int w_addr(input int w);
        return int'(bus.wr_addr[w*AW +: AW]);
    endfunction

    function automatic logic [31:0] w_val(input int w);
        return m_ext(bus.wr_data[w*32 +: 32], bus.wr_funct3[w*3 +: 3],
                     bus.wr_byte_off[w*2 +: 2], bus.wr_is_load[w]);
    endfunction

    // Expected combinational read of register a given the currently driven inputs.
    function automatic void exp_read(input int a, output logic [31:0] d, output logic b);
        d = (a == 0) ? 32'h0 : m_reg[a];
        b = (a == 0) ? 1'b0 : m_busy[a];
`ifdef REGFILE_BYPASS_EN
        if (a != 0) begin
            int win;
            win = -1;
            for (int w = 0; w < NWR; w++)
                if (bus.wr_en[w] && w_addr(w) == a) win = w;
            if (win >= 0) begin
                d = w_val(win);
                if (bus.wr_clr_busy[win] && !(bus.sb_set_en && int'(bus.sb_set_addr) == a))
                    b = 1'b0;
            end
        end
`endif
    endfunction

    function automatic bit m_any();
        for (int i = 0; i < NR; i++) if (m_busy[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < NR; i++) begin
            m_reg[i]  = 32'h0;
            m_busy[i] = 1'b0;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        bus.rd_addr     = '0;
        bus.wr_en       = '0;
        bus.wr_addr     = '0;
        bus.wr_data     = '0;
        bus.wr_is_load  = '0;
        bus.wr_funct3   = '0;
        bus.wr_byte_off = '0;
        bus.wr_clr_busy = '0;
        bus.sb_set_en   = 1'b0;
        bus.sb_set_addr = '0;
    endtask

    task automatic drive_wr(input int w, input int a, input logic [31:0] d, input logic ld,
                            input logic [2:0] f3, input logic [1:0] off, input logic clr);
        bus.wr_en[w]               = 1'b1;
        bus.wr_addr[w*AW +: AW]    = AW'(a);
        bus.wr_data[w*32 +: 32]    = d;
        bus.wr_is_load[w]          = ld;
        bus.wr_funct3[w*3 +: 3]    = f3;
        bus.wr_byte_off[w*2 +: 2]  = off;
        bus.wr_clr_busy[w]         = clr;
    endtask

    task automatic set_rd(input int p, input int a);
        bus.rd_addr[p*AW +: AW] = AW'(a);
    endtask

    // Advance one clock, updating the model from the inputs held across the edge.
    task automatic tick();
        logic [31:0] nr [NR];
        bit          nb [NR];
        nr = m_reg;
        nb = m_busy;
        for (int w = 0; w < NWR; w++) begin
            if (bus.wr_en[w] && w_addr(w) != 0) begin
                nr[w_addr(w)] = w_val(w);
                if (bus.wr_clr_busy[w]) nb[w_addr(w)] = 1'b0;
                else                    nb[w_addr(w)] = m_busy[w_addr(w)];
            end
        end
        if (bus.sb_set_en && bus.sb_set_addr != 0) nb[bus.sb_set_addr] = 1'b1;
        @(posedge clk);
        if (rst) m_clear();
        else begin
            m_reg  = nr;
            m_busy = nb;
        end
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] ed;
        logic        eb;
        idle();
        for (int p = 0; p < NRD; p++) set_rd(p, p + 4);
        #1;
        for (int p = 0; p < NRD; p++) begin
            checks++;
            if (bus.rd_data[p*32 +: 32] !== 32'h0 || bus.rd_busy[p] !== 1'b0) begin
                errors++;
                $display("FAIL reset_state port%0d data=%h busy=%b want 0/0", p,
                         bus.rd_data[p*32 +: 32], bus.rd_busy[p]);
            end
        end
        checks++;
        if (bus.any_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_any_busy got %b want 0", bus.any_busy);
        end
        // write x5 and mark it busy, then reset in the middle of a later write
        drive_wr(0, 5, 32'hDEAD_BEEF, 1'b0, 3'b0, 2'b0, 1'b0);
        bus.sb_set_en = 1'b1;
        bus.sb_set_addr = AW'(5);
        tick();
        idle();
        set_rd(0, 5);
        #1;
        checks++;
        if (bus.rd_data[31:0] !== 32'hDEAD_BEEF || bus.any_busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_x5 data=%h any=%b want deadbeef/1", bus.rd_data[31:0], bus.any_busy);
        end
        drive_wr(0, 5, 32'h0000_0123, 1'b0, 3'b0, 2'b0, 1'b0);
        drive_wr(1, 6, 32'h0000_0456, 1'b0, 3'b0, 2'b0, 1'b0);
        rst = 1'b1;
        #1;
        checks++;
        if (bus.rd_data[31:0] !== 32'h0 || bus.any_busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_x5 data=%h any=%b want 0/0", bus.rd_data[31:0], bus.any_busy);
        end
        tick();
        rst = 1'b0;
        idle();
        set_rd(0, 5);
        set_rd(1, 6);
        #1;
        for (int p = 0; p < 2; p++) begin
            exp_read(p + 5, ed, eb);
            checks++;
            if (bus.rd_data[p*32 +: 32] !== ed || ed !== 32'h0) begin
                errors++;
                $display("FAIL reset_blocks_write port%0d got %h want 0", p, bus.rd_data[p*32 +: 32]);
            end
        end
    endtask

    task automatic test_load_ext();
        logic [31:0] want [6];
        logic [2:0]  f3   [6];
        logic [1:0]  off  [6];
        want = '{32'hFFFF_FF80, 32'h0000_0081, 32'hFFFF_8070, 32'h0000_8070, 32'h8070_F081, 32'h8070_F081};
        f3   = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b011};
        off  = '{2'd3, 2'd0, 2'd2, 2'd2, 2'd1, 2'd2};
        for (int i = 0; i < 6; i++) begin
            idle();
            drive_wr(i % 2, i + 1, 32'h8070_F081, 1'b1, f3[i], off[i], 1'b0);
            tick();
        end
        idle();
        for (int i = 0; i < 6; i++) begin
            set_rd(i % NRD, i + 1);
            #1;
            checks++;
            if (bus.rd_data[(i % NRD)*32 +: 32] !== want[i] || m_reg[i + 1] !== want[i]) begin
                errors++;
                $display("FAIL load_ext case%0d f3=%b got %h want %h", i, f3[i],
                         bus.rd_data[(i % NRD)*32 +: 32], want[i]);
            end
        end
    endtask

    task automatic test_conflict();
        idle();
        drive_wr(0, 7, 32'h11, 1'b0, 3'b0, 2'b0, 1'b0);
        drive_wr(1, 7, 32'h22, 1'b0, 3'b0, 2'b0, 1'b0);
        tick();
        drive_wr(0, 0, 32'h33, 1'b0, 3'b0, 2'b0, 1'b0);
        drive_wr(1, 0, 32'h44, 1'b0, 3'b0, 2'b0, 1'b0);
        bus.sb_set_en = 1'b1;
        bus.sb_set_addr = '0;
        tick();
        idle();
        set_rd(0, 7);
        set_rd(1, 0);
        #1;
        checks++;
        if (bus.rd_data[31:0] !== 32'h22) begin
            errors++;
            $display("FAIL conflict_x7 got %h want 00000022", bus.rd_data[31:0]);
        end
        checks++;
        if (bus.rd_data[63:32] !== 32'h0 || bus.rd_busy[1] !== 1'b0) begin
            errors++;
            $display("FAIL x0_write got %h busy %b want 0/0", bus.rd_data[63:32], bus.rd_busy[1]);
        end
    endtask

    task automatic test_scoreboard();
        idle();
        set_rd(0, 3);
        bus.sb_set_en = 1'b1;
        bus.sb_set_addr = AW'(3);
        #1;
        checks++;
        if (bus.rd_busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL sb_set_same_cycle got %b want 0", bus.rd_busy[0]);
        end
        tick();
        #1;
        checks++;
        if (bus.rd_busy[0] !== 1'b1 || bus.any_busy !== 1'b1) begin
            errors++;
            $display("FAIL sb_set_next got %b/%b want 1/1", bus.rd_busy[0], bus.any_busy);
        end
        drive_wr(0, 3, 32'hA5, 1'b0, 3'b0, 2'b0, 1'b1);
        #1;
        checks++;
        if (bus.rd_busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL sb_set_clr_same_cycle got %b want 1", bus.rd_busy[0]);
        end
        tick();
        #1;
        checks++;
        if (bus.rd_busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL sb_set_wins got %b want 1", bus.rd_busy[0]);
        end
        bus.sb_set_en = 1'b0;
        drive_wr(1, 3, 32'h5A, 1'b0, 3'b0, 2'b0, 1'b1);
        #1;
        checks++;
`ifdef REGFILE_BYPASS_EN
        if (bus.rd_busy[0] !== 1'b0) begin
`else
        if (bus.rd_busy[0] !== 1'b1) begin
`endif
            errors++;
            $display("FAIL sb_clr_same_cycle got %b", bus.rd_busy[0]);
        end
        tick();
        idle();
        set_rd(0, 3);
        #1;
        checks++;
        if (bus.rd_busy[0] !== 1'b0 || bus.any_busy !== 1'b0 || bus.rd_data[31:0] !== 32'h5A) begin
            errors++;
            $display("FAIL sb_clr got busy=%b any=%b data=%h want 0/0/5a",
                     bus.rd_busy[0], bus.any_busy, bus.rd_data[31:0]);
        end
    endtask

    task automatic test_bypass();
        idle();
        drive_wr(0, 9, 32'h55, 1'b0, 3'b0, 2'b0, 1'b0);
        tick();
        drive_wr(1, 9, 32'h1234, 1'b0, 3'b0, 2'b0, 1'b0);
        set_rd(2, 9);
        #1;
        checks++;
`ifdef REGFILE_BYPASS_EN
        if (bus.rd_data[64 +: 32] !== 32'h1234) begin
`else
        if (bus.rd_data[64 +: 32] !== 32'h55) begin
`endif
            errors++;
            $display("FAIL bypass_same_cycle got %h", bus.rd_data[64 +: 32]);
        end
        tick();
        idle();
        set_rd(2, 9);
        #1;
        checks++;
        if (bus.rd_data[64 +: 32] !== 32'h1234) begin
            errors++;
            $display("FAIL bypass_next_cycle got %h want 00001234", bus.rd_data[64 +: 32]);
        end
    endtask

    task automatic test_random();
        logic [31:0] ed;
        logic        eb;
        for (int c = 0; c < 10000; c++) begin
            idle();
            for (int w = 0; w < NWR; w++) begin
                if ($urandom_range(0, 2) != 0)
                    drive_wr(w, $urandom_range(0, NR - 1), $urandom, 1'($urandom),
                             3'($urandom), 2'($urandom), 1'($urandom));
            end
            bus.sb_set_en   = ($urandom_range(0, 3) == 0);
            bus.sb_set_addr = AW'($urandom);
            for (int p = 0; p < NRD; p++) set_rd(p, $urandom_range(0, NR - 1));
            #1;
            for (int p = 0; p < NRD; p++) begin
                exp_read(int'(bus.rd_addr[p*AW +: AW]), ed, eb);
                checks++;
                if (bus.rd_data[p*32 +: 32] !== ed || bus.rd_busy[p] !== eb) begin
                    errors++;
                    $display("FAIL random c%0d port%0d x%0d got %h/%b want %h/%b", c, p,
                             bus.rd_addr[p*AW +: AW], bus.rd_data[p*32 +: 32], bus.rd_busy[p], ed, eb);
                end
            end
            checks++;
            if (bus.any_busy !== m_any()) begin
                errors++;
                $display("FAIL random_any_busy c%0d got %b want %b", c, bus.any_busy, m_any());
            end
            tick();
        end
    endtask

    initial begin
        m_clear();
        idle();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_load_ext();
        test_conflict();
        test_scoreboard();
        test_bypass();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the RV32 pipeline. It supports several read and write ports, sub-word load alignment with sign/zero extension, and a per-register busy scoreboard for in-flight producers. It replaces the single-writer register file between ID (reads, scoreboard set) and WB (writes, scoreboard clear), and lets the dual-issue core share one storage array.

## Interface
Parameters:
- NUM_REGS, 32, architectural register count; 16 (RV32E) or 32; ADDR_W = $clog2(NUM_REGS).
- NUM_RD, 2, read ports; 1..4.
- NUM_WR, 1, write ports; 1..2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port p in slice p.
- rd_data  out  NUM_RD*32  read data, combinational.
- rd_busy  out  NUM_RD  scoreboard bit of each addressed register, combinational.
- wr_en  in  NUM_WR  write strobe per port.
- wr_addr  in  NUM_WR*ADDR_W  destination per port.
- wr_data  in  NUM_WR*32  raw write data; for loads, the unaligned memory word.
- wr_is_load  in  NUM_WR  port carries load data; apply alignment/extension.
- wr_funct3  in  NUM_WR*3  load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- wr_byte_off  in  NUM_WR*2  address[1:0] of the load.
- wr_clr_busy  in  NUM_WR  the write retires the scoreboard entry of wr_addr.
- sb_set_en  in  1  ID marks a destination as pending.
- sb_set_addr  in  ADDR_W  destination to mark.
- any_busy  out  1  OR of all busy bits; drives fence/drain logic.

## Operation
- Storage: NUM_REGS x 32 flops plus NUM_REGS busy flops. x0 reads 0 and is never busy; writes and sets to x0 are dropped.
- Write path per port: if wr_is_load, the load-extension unit produces the value, otherwise wr_data passes through.
  - LB/LBU select byte wr_byte_off.
  - LH/LHU select halfword wr_byte_off[1]; wr_byte_off[0] is ignored, since misalignment is trapped upstream.
  - LW ignores the offset.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - Undefined funct3 codes (011, 110, 111) write the raw word.
- Multiple writes: write ports commit in parallel. On equal addresses the higher-index port wins, for both data and busy clear.
- Scoreboard:
  - sb_set_en sets busy[sb_set_addr] at the clock edge.
  - wr_en & wr_clr_busy clears busy[wr_addr].
  - Set and clear of the same register in the same cycle leaves it set, because the newer producer wins.
  - Set of an already-busy register keeps it set; there is no counting.
- Reads: rd_data/rd_busy are combinational from the array (see Configuration for bypass).

## Timing
- Write latency 1 cycle: data is visible at rd_data the cycle after wr_en, or the same cycle with bypass.
- Scoreboard set/clear take effect at the next edge. rd_busy in the set cycle reflects the old value.
- Reset: all registers 0, all busy 0. Outputs after reset: rd_data = 0, rd_busy = 0, any_busy = 0.
- Reset asserted mid-operation overrides pending writes and sets in that cycle. No write is committed while rst is high.
- No backpressure: every write strobe is accepted.

## Configuration
- REGFILE_BYPASS_EN defined: each read port forwards the extended write value when a same-cycle write hits its address (non-zero), with the highest-index port winning. rd_busy for that port reads 0 if that write also clears busy and no same-cycle set targets the register.
- REGFILE_BYPASS_EN undefined: reads return array contents only, and same-cycle writes appear the next cycle.

## Structure
- regfile_pkg: load funct3 constants (LB_F3, LH_F3, LW_F3, LBU_F3, LHU_F3), XLEN = 32, and the ADDR_W helper function.
- Sub-module load_ext_unit: combinational aligner/extender, inputs data, funct3, byte_off, is_load, output 32-bit value. One instance per write port.

## Test plan
- Reset: write x5=0xDEADBEEF, assert rst mid-cycle -> all reads 0, any_busy 0.
- Load extension: wr_data 0x8070F081, LB off=3 -> 0xFFFFFF80; LBU off=0 -> 0x00000081; LH off=2 -> 0xFFFF8070; LHU off=2 -> 0x00008070; LW -> 0x8070F081.
- Write conflict: NUM_WR=2, both ports write x7 (0x11, 0x22) -> x7 reads 0x22. Both write x0 -> x0 stays 0.
- Scoreboard: set x3 cycle 0 -> rd_busy 1 from cycle 1. In the same cycle, set x3 and write x3 with clr -> still busy. Clear only -> busy 0 next cycle, any_busy 0.
- Bypass (REGFILE_BYPASS_EN): write x9=0x1234 with rd_addr=x9 in the same cycle -> rd_data 0x1234 in that cycle. Without the macro -> old value, then 0x1234 next cycle.
- Parameter sweep: NUM_REGS=16, NUM_RD=4, random writes/reads against a reference model for 10k cycles -> zero mismatches.
